// File: rtl/wb_slot_mux_if.sv
// Wishbone slave-port bundle between the management SoC and wb_slot_mux.
// The master modport is the SoC side and the slave modport is the interconnect side.
interface wb_slot_mux_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_slot_mux.sv
// Wishbone slot interconnect: decodes the SoC slave port into NSLOTS fixed-size
// slot windows plus one local control window. It forwards one transaction at a time,
// answers unmapped addresses itself and aggregates edge-triggered interrupts.
// Optional feature: define WB_SLOT_MUX_TIMEOUT_EN to abort slots that never ack
// (TO_FLAG/TO_SLOT in STATUS, user_irq[1]).
module wb_slot_mux #(
   parameter int unsigned NSLOTS  = 4,
   parameter int unsigned SLOT_AW = 12,
   parameter logic [31:0] BASE    = 32'h3000_0000,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned NIRQ    = 8
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   wb_slot_mux_if.slave           wbs,
   output logic [NSLOTS-1:0]      s_cyc_o,
   output logic [NSLOTS-1:0]      s_stb_o,
   output logic                   s_we_o,
   output logic [3:0]             s_sel_o,
   output logic [SLOT_AW-1:0]     s_adr_o,
   output logic [31:0]            s_dat_o,
   input  logic [NSLOTS-1:0]      s_ack_i,
   input  logic [32*NSLOTS-1:0]   s_dat_i,
   input  logic [NIRQ-1:0]        irq_src_i,
   output logic [2:0]             user_irq
);

   typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_LOCAL, ST_ACK} state_t;

   localparam logic [31:0]        DAT_UNMAPPED = 32'hBADA_DD00;
   localparam logic [31:0]        DAT_TIMEOUT  = 32'hDEAD_0000;
   localparam logic [SLOT_AW-3:0] WORD_PEND    = (SLOT_AW-2)'(0);
   localparam logic [SLOT_AW-3:0] WORD_MASK    = (SLOT_AW-2)'(1);
   localparam logic [SLOT_AW-3:0] WORD_STATUS  = (SLOT_AW-2)'(2);

   state_t              r_state, w_state_nxt;
   logic [SLOT_AW-1:0]  r_adr;
   logic [31:0]         r_wdat;
   logic [3:0]          r_sel;
   logic                r_we;
   logic [3:0]          r_idx;
   logic                r_is_ctrl;
   logic [31:0]         r_rdat;
   logic [NIRQ-1:0]     r_pend, r_mask, r_src_d;

   logic                w_req, w_mapped, w_is_slot, w_is_ctrl;
   logic [31:0]         w_off, w_idx;
   logic [NSLOTS-1:0]   w_onehot;
   logic                w_slot_ack;
   logic [31:0]         w_slot_dat;
   logic                w_timeout, w_to_irq;
   logic [31:0]         w_status, w_local_rdat, w_wmask;
   logic                w_reg_wr;
   logic [SLOT_AW-3:0]  w_word;
   logic [NIRQ-1:0]     w_pend_clr, w_mask_nxt;

   // Address decode of the incoming request into slot / control / unmapped.
   always_comb begin
      w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
      w_off     = wbs.wbs_adr_i - BASE;
      w_idx     = w_off >> SLOT_AW;
      w_mapped  = (wbs.wbs_adr_i >= BASE);
      w_is_slot = w_mapped && (w_idx < NSLOTS);
      w_is_ctrl = w_mapped && (w_idx == NSLOTS);
   end

   // Select the latched slot: one-hot strobe vector, its ack and its read-data slice.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
      w_onehot   = '0;
      w_slot_ack = 1'b0;
      w_slot_dat = '0;
      for (int k = 0; k < NSLOTS; k++) begin
         if (r_idx == 4'(k)) begin
            w_onehot[k] = 1'b1;
            w_slot_ack  = s_ack_i[k];
            w_slot_dat  = s_dat_i[32*k +: 32];
         end
      end
   end

`ifdef WB_SLOT_MUX_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_to_flag;
   logic [2:0]  r_to_slot;

   // The counter holds the number of FWD edges already spent, so the TIMEOUT-th one aborts.
   assign w_timeout = ((r_cnt + 16'd1) == 16'(TIMEOUT));
   assign w_status  = {25'd0, r_to_slot, 3'd0, r_to_flag};
   assign w_to_irq  = r_to_flag;

   // Wait counter plus sticky timeout flag and the slot that caused it.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_cnt     <= '0;
         r_to_flag <= 1'b0;
         r_to_slot <= '0;
      end else begin
         if (r_state == ST_IDLE && w_req)
            r_cnt <= '0;
         else if (r_state == ST_FWD)
            r_cnt <= r_cnt + 16'd1;
         if (r_state == ST_FWD && wbs.wbs_cyc_i && !w_slot_ack && w_timeout) begin
            r_to_flag <= 1'b1;
            r_to_slot <= r_idx[2:0];
         end else if (w_reg_wr && w_word == WORD_STATUS && r_sel[0] && r_wdat[0]) begin
            r_to_flag <= 1'b0;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_status  = '0;
   assign w_to_irq  = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!wb_rst_ni) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   // FSM next state: master abort beats slave ack, which beats timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_req) w_state_nxt = w_is_slot ? ST_FWD : ST_LOCAL;
         ST_FWD:   if (!wbs.wbs_cyc_i)             w_state_nxt = ST_IDLE;
                   else if (w_slot_ack || w_timeout) w_state_nxt = ST_ACK;
         ST_LOCAL: w_state_nxt = wbs.wbs_cyc_i ? ST_ACK : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: decoded from the state flops only, with no input-to-output path.
   always_comb begin
      s_cyc_o       = (r_state == ST_FWD) ? w_onehot : '0;
      s_stb_o       = (r_state == ST_FWD) ? w_onehot : '0;
      wbs.wbs_ack_o = (r_state == ST_ACK);
   end

   assign wbs.wbs_dat_o = r_rdat;
   assign s_we_o        = r_we;
   assign s_sel_o       = r_sel;
   assign s_adr_o       = r_adr;
   assign s_dat_o       = r_wdat;
   assign user_irq      = {1'b0, w_to_irq, |(r_pend & r_mask)};

   // Local register decode and read mux; unmapped accesses read the fixed pattern.
   always_comb begin
      w_word   = r_adr[SLOT_AW-1:2];
      w_reg_wr = (r_state == ST_LOCAL) && wbs.wbs_cyc_i && r_is_ctrl && r_we;
      w_wmask  = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
      if (!r_is_ctrl)                w_local_rdat = DAT_UNMAPPED;
      else if (w_word == WORD_PEND)   w_local_rdat = 32'(r_pend);
      else if (w_word == WORD_MASK)   w_local_rdat = 32'(r_mask);
      else if (w_word == WORD_STATUS) w_local_rdat = w_status;
      else                            w_local_rdat = '0;
   end

   // Byte-enabled write-1-to-clear for IRQ_PEND and plain write for IRQ_MASK.
   always_comb begin
      w_pend_clr = '0;
      w_mask_nxt = r_mask;
      for (int i = 0; i < NIRQ; i++) begin
         if (w_reg_wr && w_wmask[i] && w_word == WORD_PEND) w_pend_clr[i] = r_wdat[i];
         if (w_reg_wr && w_wmask[i] && w_word == WORD_MASK) w_mask_nxt[i] = r_wdat[i];
      end
   end

   // Request latch and response data capture.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_adr     <= '0;
         r_wdat    <= '0;
         r_sel     <= '0;
         r_we      <= 1'b0;
         r_idx     <= '0;
         r_is_ctrl <= 1'b0;
         r_rdat    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_req) begin
               r_adr     <= wbs.wbs_adr_i[SLOT_AW-1:0];
               r_wdat    <= wbs.wbs_dat_i;
               r_sel     <= wbs.wbs_sel_i;
               r_we      <= wbs.wbs_we_i;
               r_idx     <= w_idx[3:0];
               r_is_ctrl <= w_is_ctrl;
            end
            ST_FWD: if (wbs.wbs_cyc_i) begin
               if (w_slot_ack)     r_rdat <= w_slot_dat;
               else if (w_timeout) r_rdat <= DAT_TIMEOUT | 32'(r_idx);
            end
            ST_LOCAL: if (wbs.wbs_cyc_i) r_rdat <= w_local_rdat;
            default: ;
         endcase
      end
   end

   // Interrupt edge detection; a new rising edge wins over a same-cycle clear.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_src_d <= '0;
         r_pend  <= '0;
         r_mask  <= '0;
      end else begin
         r_src_d <= irq_src_i;
         r_pend  <= (r_pend & ~w_pend_clr) | (irq_src_i & ~r_src_d);
         r_mask  <= w_mask_nxt;
      end
   end

endmodule
